// File: rtl/ip_codma_pkg.sv
// Shared CODMA package: bus geometry defaults and the read-machine state type.
package ip_codma_pkg;

   localparam int unsigned CODMA_ADDR_W    = 32;
   localparam int unsigned CODMA_DATA_W    = 32;
   localparam int unsigned CODMA_MAX_WORDS = 8;

   typedef enum logic [1:0] {
      RD_IDLE    = 2'd0,
      RD_ASK     = 2'd1,
      RD_GRANTED = 2'd2,
      RD_UNUSED  = 2'd3
   } read_state_t;

endpackage

// File: rtl/ip_codma_rd_machine_if.sv
// System-bus read channel between the CODMA read machine (master) and the bus (slave).
//   bus_read_o  : read request            (master -> slave)
//   bus_addr_o  : base byte address       (master -> slave)
//   bus_gnt_i   : request granted         (slave -> master)
//   bus_valid_i : read beat valid         (slave -> master)
//   bus_rdata_i : read beat data          (slave -> master)
//   bus_error_i : error response          (slave -> master)
interface ip_codma_rd_machine_if
   import ip_codma_pkg::*;
#(
   parameter int unsigned ADDR_W = CODMA_ADDR_W,
   parameter int unsigned DATA_W = CODMA_DATA_W
);

   logic              bus_read_o;
   logic [ADDR_W-1:0] bus_addr_o;
   logic              bus_gnt_i;
   logic              bus_valid_i;
   logic [DATA_W-1:0] bus_rdata_i;
   logic              bus_error_i;

   modport master (
      output bus_read_o,
      output bus_addr_o,
      input  bus_gnt_i,
      input  bus_valid_i,
      input  bus_rdata_i,
      input  bus_error_i
   );

   modport slave (
      input  bus_read_o,
      input  bus_addr_o,
      output bus_gnt_i,
      output bus_valid_i,
      output bus_rdata_i,
      output bus_error_i
   );

endinterface

// File: rtl/ip_codma_rd_machine.sv
// CODMA read-side bus master. Accepts a base address and beat count from the DMA
// state machine, runs the request/grant handshake, gathers the returned beats into
// a local buffer and reports completion with done/error pulses.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   rd_start_i     : one-cycle start; rd_addr_i / rd_words_i sampled with it
//   rd_busy_o      : machine not idle
//   rd_done_o      : one-cycle pulse, rd_data_o valid
//   rd_error_o     : one-cycle pulse, read aborted
//   rd_data_o      : buffer, word i at [i*DATA_W +: DATA_W]
//   bus            : read channel (master modport)
// Optional build macro CODMA_RD_TIMEOUT_EN adds a watchdog that aborts after
// TIMEOUT_CYCLES consecutive cycles without grant/beat progress.
module ip_codma_rd_machine
   import ip_codma_pkg::*;
#(
   parameter int unsigned DATA_W         = CODMA_DATA_W,
   parameter int unsigned MAX_WORDS      = CODMA_MAX_WORDS,
   parameter int unsigned CNT_W          = $clog2(MAX_WORDS + 1),
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          rd_start_i,
   input  logic [CODMA_ADDR_W-1:0]       rd_addr_i,
   input  logic [CNT_W-1:0]              rd_words_i,
   output logic                          rd_busy_o,
   output logic                          rd_done_o,
   output logic                          rd_error_o,
   output logic [MAX_WORDS*DATA_W-1:0]   rd_data_o,
   ip_codma_rd_machine_if.master         bus
);

   read_state_t                           state_q, state_d;
   logic                                  done_d, error_d;
   logic                                  accept_c, beat_c, wd_expire_c;
   logic                                  read_q;
   logic [CODMA_ADDR_W-1:0]               addr_q;
   logic [CNT_W-1:0]                      words_q, count_q;
   logic [MAX_WORDS-1:0][DATA_W-1:0]      buf_q;

   assign bus.bus_read_o = read_q;
   assign bus.bus_addr_o = addr_q;
   assign rd_data_o      = buf_q;

   // Next-state and pulse decode; bus_error_i outranks grant and beats.
   always_comb begin
      state_d  = state_q;
      done_d   = 1'b0;
      error_d  = 1'b0;
      accept_c = 1'b0;
      beat_c   = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (rd_start_i) begin
               accept_c = 1'b1;
               if (rd_words_i == '0) begin
                  done_d = 1'b1;
               end else if (rd_words_i > CNT_W'(MAX_WORDS)) begin
                  error_d = 1'b1;
               end else begin
                  state_d = RD_ASK;
               end
            end
         end
         RD_ASK: begin
            if (bus.bus_error_i) begin
               state_d = RD_IDLE;
               error_d = 1'b1;
            end else if (bus.bus_gnt_i) begin
               state_d = RD_GRANTED;
            end else if (wd_expire_c) begin
               state_d = RD_IDLE;
               error_d = 1'b1;
            end
         end
         RD_GRANTED: begin
            if (bus.bus_error_i) begin
               state_d = RD_IDLE;
               error_d = 1'b1;
            end else if (bus.bus_valid_i) begin
               beat_c = 1'b1;
               if ((count_q + CNT_W'(1)) == words_q) begin
                  state_d = RD_IDLE;
                  done_d  = 1'b1;
               end
            end else if (wd_expire_c) begin
               state_d = RD_IDLE;
               error_d = 1'b1;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // State, registered outputs, request latch and beat buffer.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= RD_IDLE;
         rd_busy_o  <= 1'b0;
         rd_done_o  <= 1'b0;
         rd_error_o <= 1'b0;
         read_q     <= 1'b0;
         addr_q     <= '0;
         words_q    <= '0;
         count_q    <= '0;
         buf_q      <= '0;
      end else begin
         state_q    <= state_d;
         rd_busy_o  <= (state_d != RD_IDLE);
         rd_done_o  <= done_d;
         rd_error_o <= error_d;
         read_q     <= (state_d == RD_ASK);
         if (accept_c) begin
            addr_q  <= rd_addr_i;
            words_q <= rd_words_i;
            count_q <= '0;
            buf_q   <= '0;
         end else if (beat_c) begin
            for (int unsigned i = 0; i < MAX_WORDS; i++) begin
               if (count_q == CNT_W'(i)) buf_q[i] <= bus.bus_rdata_i;
            end
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

`ifdef CODMA_RD_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_q;
   logic            wd_idle_c;

   // A cycle is idle when the bus makes no progress in the current phase.
   assign wd_idle_c   = ((state_q == RD_ASK)     && !bus.bus_gnt_i) ||
                        ((state_q == RD_GRANTED) && !bus.bus_valid_i);
   assign wd_expire_c = wd_idle_c && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   // Consecutive idle-cycle counter; cleared on progress or phase change.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wd_q <= '0;
      end else if (wd_idle_c && (state_d == state_q)) begin
         wd_q <= wd_q + WD_W'(1);
      end else begin
         wd_q <= '0;
      end
   end
`else
   assign wd_expire_c = 1'b0;

   // Watchdog compiled out: the limit is carried only to keep one parameter list.
   if (TIMEOUT_CYCLES == 0) begin : g_wd_absent
   end
`endif

endmodule
